chan_sync_sink: RTL and testbench

- Clocked consumer that terminates a bundled-data req/ack/dat channel, e.g. the output of an hlatch pipeline.
- Acts as the receiving end of the 4-phase handshake: synchronises req and dat, acknowledges each token, and deserialises the 1-bit tokens into W-bit words.
- Words are presented on a synchronous valid/ready port, bridging the self-timed fabric into clocked logic.

---
 rtl/chan_sync_sink_pkg.sv | 17 +
 rtl/chan_sync_sink_if.sv | 23 ++
 rtl/chan_sync_sink_sync_ff.sv | 24 ++
 rtl/chan_sync_sink.sv | 122 ++++++++++++
 tb/tb_chan_sync_sink.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/chan_sync_sink_pkg.sv
// Shared types and helpers for the bundled-data channel sink.
package chan_pkg;

  localparam int CHAN_SYNC_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    RTZ
  } state_t;

  // Width of the token counter; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/chan_sync_sink_if.sv
// Bundled-data input channel plus valid/ready word output of chan_sync_sink.
interface chan_sync_sink_if #(
  parameter int W = 8
);

  logic         req_i;
  logic         ack_o;
  logic         dat_i;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output req_i, dat_i, out_ready,
    input  ack_o, out_data, out_valid
  );

  modport slave (
    input  req_i, dat_i, out_ready,
    output ack_o, out_data, out_valid
  );

endinterface

// File: rtl/chan_sync_sink_sync_ff.sv
// N-stage single-bit synchroniser with asynchronous active-high reset.
module sync_ff
  import chan_pkg::*;
#(
  parameter int N = CHAN_SYNC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbour; blocking = would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[N-2:0], d};
  end

  assign q = chain[N-1];

endmodule

// File: rtl/chan_sync_sink.sv
// Clocked sink for a 4-phase bundled-data channel: acks 1-bit tokens and packs them LSB-first into W-bit words.
// Optional handshake timeout (sticky err_o) is built only when CHAN_SYNC_SINK_TIMEOUT_EN is defined.
module chan_sync_sink
  import chan_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = CHAN_SYNC_DEFAULT,
  parameter int TIMEOUT     = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  chan_sync_sink_if.slave         ch,
  output logic [cnt_width(W)-1:0] bit_cnt,
  output logic                    err_o
);

  localparam int             CW   = cnt_width(W);
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  if (W < 2 || SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("chan_sync_sink: W and SYNC_STAGES must be >= 2, TIMEOUT >= 1");
  end

  logic req_s;
  logic dat_s;

  sync_ff #(.N(SYNC_STAGES)) u_req_sync (.clk(clk), .rst(rst), .d(ch.req_i), .q(req_s));
  sync_ff #(.N(SYNC_STAGES)) u_dat_sync (.clk(clk), .rst(rst), .d(ch.dat_i), .q(dat_s));

  state_t       state, state_next;
  logic         ack_q, ack_d;
  logic         capture;
  logic         stall;
  logic [W-1:0] shift;
  logic [W-1:0] data_q;
  logic         valid_q;

  // The last token of a word waits while the previous word is still unread.
  assign stall = (bit_cnt == LAST) && valid_q && !ch.out_ready;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: if (req_s && !stall) begin
        capture    = 1'b1;
        state_next = ACK;
      end
      ACK:     state_next = RTZ;
      RTZ:     if (!req_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    ack_d = (state_next == RTZ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ack_q <= 1'b0;
    end else begin
      state <= state_next;
      ack_q <= ack_d;
    end
  end

  // A completing word overrides the consume-clear, so a word accepted in the
  // same cycle is replaced rather than dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (valid_q && ch.out_ready) valid_q <= 1'b0;
      if (capture) begin
        if (bit_cnt == LAST) begin
          data_q  <= {dat_s, shift[W-2:0]};
          valid_q <= 1'b1;
          bit_cnt <= '0;
        end else begin
          shift[bit_cnt] <= dat_s;
          bit_cnt        <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign ch.ack_o     = ack_q;
  assign ch.out_data  = data_q;
  assign ch.out_valid = valid_q;

`ifdef CHAN_SYNC_SINK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_next;
  logic          err_q;

  assign to_next = (to_cnt == TW'(TIMEOUT)) ? to_cnt : to_cnt + 1'b1;

  // Counter restarts on every RTZ entry and saturates at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else if (state == ACK) begin
      to_cnt <= '0;
    end else if (state == RTZ) begin
      to_cnt <= to_next;
      if (to_next == TW'(TIMEOUT) && req_s) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_chan_sync_sink.sv
// Directed self-checking bench for chan_sync_sink (W=8, SYNC_STAGES=2, TIMEOUT=16).
module tb_chan_sync_sink;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] bit_cnt;
  logic       err_o;

  chan_sync_sink_if #(.W(W)) ch ();

  chan_sync_sink #(
    .W(W),
    .SYNC_STAGES(2),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch(ch.slave),
    .bit_cnt(bit_cnt),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: words transferred on the output port and valid-high cycles.
  logic [W-1:0] words[$];
  int           valid_cycles;
  bit           err_seen;

  always @(negedge clk) begin
    if (!rst) begin
      if (ch.out_valid) valid_cycles++;
      if (ch.out_valid && ch.out_ready) words.push_back(ch.out_data);
      if (err_o) err_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pop_word();
    if (words.size() == 0) return 32'hxxxx_xxxx;
    return {24'h0, words.pop_front()};
  endfunction

  task automatic token_start(input logic d);
    @(posedge clk);
    #1 ch.dat_i = d;
    #1 ch.req_i = 1'b1;
  endtask

  // Bounded wait for ack_o to reach a level; a timeout shows as a failed check.
  task automatic wait_ack(input string tag, input logic level, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (ch.ack_o !== level && edges < 20);
    check(tag, ch.ack_o, level);
  endtask

  task automatic send_token(input logic d, input bit chk_lat);
    int e;
    token_start(d);
    wait_ack("ack_rise", 1'b1, e);
    if (chk_lat) check("ack_rise_lat", e, 4);
    ch.req_i = 1'b0;
    wait_ack("ack_fall", 1'b0, e);
    if (chk_lat) check("ack_fall_lat", e, 3);
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits, input bit chk_lat);
    for (int i = 0; i < nbits; i++) send_token(w[i], chk_lat);
  endtask

  initial begin
    int   e;
    logic exp_err;
`ifdef CHAN_SYNC_SINK_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    ch.req_i = 1'b0;
    ch.dat_i = 1'b0;
    ch.out_ready = 1'b0;
    valid_cycles = 0;
    err_seen = 1'b0;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ch.ack_o, 0);
    check("rst_valid", ch.out_valid, 0);
    check("rst_data", ch.out_data, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_err", err_o, 0);
    #1 rst = 1'b0;

    // 1: single word 0x4D, LSB-first 1,0,1,1,0,0,1,0, ready held high
    ch.out_ready = 1'b1;
    words.delete();
    valid_cycles = 0;
    send_word(8'h4D, 8, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t1_nwords", words.size(), 1);
    check("t1_word", pop_word(), 8'h4D);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_bit_cnt", bit_cnt, 0);

    // 2: backpressure stalls the last token of the second word
    ch.out_ready = 1'b0;
    words.delete();
    send_word(8'hA5, 8, 1'b0);
    check("t2_valid_a5", ch.out_valid, 1);
    check("t2_data_a5", ch.out_data, 8'hA5);
    send_word(8'h3C, 7, 1'b0);
    check("t2_bit_cnt_7", bit_cnt, 7);
    token_start(1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("t2_stall_ack", ch.ack_o, 0);
    check("t2_stall_bit_cnt", bit_cnt, 7);
    check("t2_stall_data", ch.out_data, 8'hA5);
    check("t2_stall_valid", ch.out_valid, 1);
    ch.out_ready = 1'b1;
    wait_ack("t2_ack_rise", 1'b1, e);
    check("t2_data_3c", ch.out_data, 8'h3C);
    ch.req_i = 1'b0;
    wait_ack("t2_ack_fall", 1'b0, e);
    check("t2_nwords", words.size(), 2);
    check("t2_word0", pop_word(), 8'hA5);
    check("t2_word1", pop_word(), 8'h3C);

    // 3: second word completes on the very edge the first is accepted
    ch.out_ready = 1'b0;
    words.delete();
    send_word(8'h96, 8, 1'b0);
    send_word(8'h69, 7, 1'b0);
    token_start(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 ch.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_valid_kept", ch.out_valid, 1);
    check("t3_data_69", ch.out_data, 8'h69);
    check("t3_bit_cnt", bit_cnt, 0);
    check("t3_nwords_mid", words.size(), 1);
    wait_ack("t3_ack_rise", 1'b1, e);
    ch.req_i = 1'b0;
    wait_ack("t3_ack_fall", 1'b0, e);
    check("t3_valid_done", ch.out_valid, 0);
    check("t3_nwords", words.size(), 2);
    check("t3_word0", pop_word(), 8'h96);
    check("t3_word1", pop_word(), 8'h69);

    // 4: reset in the middle of the fourth token discards the partial word
    words.delete();
    send_word(8'h07, 3, 1'b0);
    token_start(1'b1);
    wait_ack("t4_ack_rise", 1'b1, e);
    check("t4_bit_cnt_pre", bit_cnt, 4);
    #1 rst = 1'b1;
    #1;
    check("t4_rst_ack", ch.ack_o, 0);
    check("t4_rst_bit_cnt", bit_cnt, 0);
    ch.req_i = 1'b0;
    ch.dat_i = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    words.delete();
    send_word(8'hFF, 8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_nwords", words.size(), 1);
    check("t4_word", pop_word(), 8'hFF);

    // 5: req held high 40 cycles after ack; err_o only with the timeout built in
    err_seen = 1'b0;
    token_start(1'b1);
    wait_ack("t5_ack_rise", 1'b1, e);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 15) check("t5_err_before", err_o, 0);
      if (k == 16) check("t5_err_at_16", err_o, exp_err);
    end
    ch.req_i = 1'b0;
    wait_ack("t5_ack_fall", 1'b0, e);
    repeat (2) @(posedge clk);
    #1;
    check("t5_err_sticky", err_o, exp_err);
    check("t5_err_seen", err_seen, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
